// File: rtl/lbp_engine_param_if.sv
// rtl/lbp_engine_param_if.sv - gray-read and LBP-write handshake bundle for lbp_engine_param
interface lbp_engine_param_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_valid;
  logic [7:0]        lbp_data;

  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_addr, lbp_valid, lbp_data
  );

  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_addr, lbp_valid, lbp_data
  );
endinterface

// File: rtl/lbp_engine_param.sv
// rtl/lbp_engine_param.sv - streaming 3x3 LBP engine, optional border zero-fill under LBP_BORDER_WRITE_EN
module lbp_engine_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic lbp_mode,
  output logic finish,
  lbp_engine_param_if.master bus
);

`ifdef LBP_BORDER_WRITE_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_EMIT, S_BORDER, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_EMIT, S_DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] W2_A     = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);
`ifdef LBP_BORDER_WRITE_EN
  localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(IMG_H - 1);
`endif

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [ADDR_W-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]       base_q, base_d;      // (row-1)*IMG_W, kept by adding IMG_W per row
  logic [2:0]              rd_q, rd_d;
  logic [8:0][DATA_W-1:0]  win_q, win_d;
  logic                    lbp_valid_q, lbp_valid_d;
  logic [ADDR_W-1:0]       lbp_addr_q, lbp_addr_d;
  logic [7:0]              lbp_data_q, lbp_data_d;
  logic                    finish_q, finish_d;
`ifdef LBP_BORDER_WRITE_EN
  logic [ADDR_W-1:0]       baddr_q, baddr_d;
`endif

  logic                    fetching;
  logic [1:0]              ridx, cidx;
  logic [ADDR_W-1:0]       roff, rd_addr;
  logic [3:0]              widx;
  logic [7:0]              std_code, rot_code;
  logic [15:0]             dbl;

  // Map the read counter onto a window row/column and the matching gray address.
  always_comb begin
    fetching = (state_q == S_LOAD) || (state_q == S_FETCH);
    if (state_q == S_LOAD) begin
      cidx = (rd_q >= 3'd3) ? 2'd1 : 2'd0;
      ridx = (rd_q >= 3'd3) ? 2'(rd_q - 3'd3) : rd_q[1:0];
    end else begin
      cidx = 2'd2;
      ridx = rd_q[1:0];
    end
    case (ridx)
      2'd0:    roff = '0;
      2'd1:    roff = W_A;
      default: roff = W2_A;
    endcase
    rd_addr = base_q + roff + col_q + ADDR_W'(cidx) - ONE_A;
    widx    = {2'b00, ridx} + {2'b00, ridx} + {2'b00, ridx} + {2'b00, cidx};
  end

  // Standard code from the window and its minimum over all circular rotations.
  always_comb begin
    std_code[0] = win_q[0] >= win_q[4];
    std_code[1] = win_q[1] >= win_q[4];
    std_code[2] = win_q[2] >= win_q[4];
    std_code[3] = win_q[3] >= win_q[4];
    std_code[4] = win_q[5] >= win_q[4];
    std_code[5] = win_q[6] >= win_q[4];
    std_code[6] = win_q[7] >= win_q[4];
    std_code[7] = win_q[8] >= win_q[4];
    rot_code = std_code;
    dbl      = '0;
    for (int r = 1; r < 8; r++) begin
      dbl = {std_code, std_code} >> r;
      if (dbl[7:0] < rot_code) rot_code = dbl[7:0];
    end
  end

  // Next-state logic for the sequencer, counters, window and write port.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    row_d       = row_q;
    col_d       = col_q;
    base_d      = base_q;
    rd_d        = rd_q;
    win_d       = win_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q | (state_q == S_DONE);
`ifdef LBP_BORDER_WRITE_EN
    baddr_d     = baddr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.gray_ready) begin
          state_d = S_LOAD;
          mode_d  = lbp_mode;
          rd_d    = '0;
        end
      end
      S_LOAD: begin
        if (bus.gray_ready) begin
          win_d[widx] = bus.gray_data;
          if (rd_q == 3'd5) begin
            rd_d    = '0;
            state_d = S_FETCH;
          end else begin
            rd_d = rd_q + 3'd1;
          end
        end
      end
      S_FETCH: begin
        if (bus.gray_ready) begin
          win_d[widx] = bus.gray_data;
          if (rd_q == 3'd2) begin
            rd_d    = '0;
            state_d = S_EMIT;
          end else begin
            rd_d = rd_q + 3'd1;
          end
        end
      end
      S_EMIT: begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = base_q + W_A + col_q;
        lbp_data_d  = mode_q ? rot_code : std_code;
        for (int r = 0; r < 3; r++) begin
          win_d[r*3]   = win_q[r*3+1];
          win_d[r*3+1] = win_q[r*3+2];
        end
        if (col_q < COL_LAST) begin
          col_d   = col_q + ONE_A;
          state_d = S_FETCH;
        end else if (row_q < ROW_LAST) begin
          row_d   = row_q + ONE_A;
          col_d   = ONE_A;
          base_d  = base_q + W_A;
          state_d = S_LOAD;
        end else begin
`ifdef LBP_BORDER_WRITE_EN
          row_d   = '0;
          col_d   = '0;
          baddr_d = '0;
          state_d = S_BORDER;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef LBP_BORDER_WRITE_EN
      S_BORDER: begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = baddr_q;
        lbp_data_d  = 8'h00;
        if (row_q == ROW_MAX && col_q == COL_MAX) begin
          state_d = S_DONE;
        end else if (row_q == '0 || row_q == ROW_MAX) begin
          baddr_d = baddr_q + ONE_A;
          if (col_q == COL_MAX) begin
            row_d = row_q + ONE_A;
            col_d = '0;
          end else begin
            col_d = col_q + ONE_A;
          end
        end else if (col_q == '0) begin
          col_d   = COL_MAX;
          baddr_d = baddr_q + COL_MAX;
        end else begin
          row_d   = row_q + ONE_A;
          col_d   = '0;
          baddr_d = baddr_q + ONE_A;
        end
      end
`endif
      default: ;
    endcase
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      row_q       <= ONE_A;
      col_q       <= ONE_A;
      base_q      <= '0;
      rd_q        <= '0;
      win_q       <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
`ifdef LBP_BORDER_WRITE_EN
      baddr_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      col_q       <= col_d;
      base_q      <= base_d;
      rd_q        <= rd_d;
      win_q       <= win_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
`ifdef LBP_BORDER_WRITE_EN
      baddr_q     <= baddr_d;
`endif
    end
  end

  assign bus.gray_req  = fetching && bus.gray_ready;
  assign bus.gray_addr = fetching ? rd_addr : '0;
  assign bus.lbp_valid = lbp_valid_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;
  assign finish        = finish_q;

endmodule

// File: tb/tb_lbp_engine_param.sv
// tb/tb_lbp_engine_param.sv - randomized model-checked bench for lbp_engine_param
module tb_lbp_engine_param;
  localparam int NDUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [NDUT];
  logic        mode  [NDUT];
  logic        ready [NDUT];
  logic        fin   [NDUT];
  logic        req   [NDUT];
  logic [31:0] gaddr [NDUT];
  logic        vld   [NDUT];
  logic [31:0] waddr [NDUT];
  logic [31:0] wdata [NDUT];
  logic [7:0]  img   [16384];

  int sel = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int got_a[$], got_d[$], exp_a[$], exp_d[$];
  int total = 0;
  int bad = 0;

  lbp_engine_param_if #(.ADDR_W(4), .DATA_W(8)) bus0();
  lbp_engine_param #(.IMG_W(3), .IMG_H(3), .ADDR_W(4), .DATA_W(8)) dut0 (
    .clk(clk), .reset(rst_n[0]), .lbp_mode(mode[0]), .finish(fin[0]), .bus(bus0));
  assign bus0.gray_ready = ready[0];
  assign bus0.gray_data  = (sel == 0) ? img[bus0.gray_addr] : 8'h00;
  assign req[0] = bus0.gray_req;   assign gaddr[0] = 32'(bus0.gray_addr);
  assign vld[0] = bus0.lbp_valid;  assign waddr[0] = 32'(bus0.lbp_addr);
  assign wdata[0] = 32'(bus0.lbp_data);

  lbp_engine_param_if #(.ADDR_W(5), .DATA_W(8)) bus1();
  lbp_engine_param #(.IMG_W(5), .IMG_H(4), .ADDR_W(5), .DATA_W(8)) dut1 (
    .clk(clk), .reset(rst_n[1]), .lbp_mode(mode[1]), .finish(fin[1]), .bus(bus1));
  assign bus1.gray_ready = ready[1];
  assign bus1.gray_data  = (sel == 1) ? img[bus1.gray_addr] : 8'h00;
  assign req[1] = bus1.gray_req;   assign gaddr[1] = 32'(bus1.gray_addr);
  assign vld[1] = bus1.lbp_valid;  assign waddr[1] = 32'(bus1.lbp_addr);
  assign wdata[1] = 32'(bus1.lbp_data);

  lbp_engine_param_if #(.ADDR_W(4), .DATA_W(8)) bus2();
  lbp_engine_param #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .DATA_W(8)) dut2 (
    .clk(clk), .reset(rst_n[2]), .lbp_mode(mode[2]), .finish(fin[2]), .bus(bus2));
  assign bus2.gray_ready = ready[2];
  assign bus2.gray_data  = (sel == 2) ? img[bus2.gray_addr] : 8'h00;
  assign req[2] = bus2.gray_req;   assign gaddr[2] = 32'(bus2.gray_addr);
  assign vld[2] = bus2.lbp_valid;  assign waddr[2] = 32'(bus2.lbp_addr);
  assign wdata[2] = 32'(bus2.lbp_data);

  lbp_engine_param_if #(.ADDR_W(14), .DATA_W(8)) bus3();
  lbp_engine_param #(.IMG_W(128), .IMG_H(128), .ADDR_W(14), .DATA_W(8)) dut3 (
    .clk(clk), .reset(rst_n[3]), .lbp_mode(mode[3]), .finish(fin[3]), .bus(bus3));
  assign bus3.gray_ready = ready[3];
  assign bus3.gray_data  = (sel == 3) ? img[bus3.gray_addr] : 8'h00;
  assign req[3] = bus3.gray_req;   assign gaddr[3] = 32'(bus3.gray_addr);
  assign vld[3] = bus3.lbp_valid;  assign waddr[3] = 32'(bus3.lbp_addr);
  assign wdata[3] = 32'(bus3.lbp_data);

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor for the DUT currently under test; memory samples on the falling edge.
  always @(negedge clk) begin
    if (vld[sel] === 1'b1) begin
      got_a.push_back(int'(waddr[sel]));
      got_d.push_back(int'(wdata[sel]));
      last_wr_cyc = cyc;
    end
  end

  function automatic int w_of(input int s);
    case (s) 0: return 3; 1: return 5; 2: return 4; default: return 128; endcase
  endfunction

  function automatic int h_of(input int s);
    case (s) 0: return 3; 1: return 4; 2: return 4; default: return 128; endcase
  endfunction

  function automatic int border_writes(input int w, input int h);
`ifdef LBP_BORDER_WRITE_EN
    return 2 * w + 2 * (h - 2);
`else
    return 0 * (w + h);
`endif
  endfunction

  function automatic int exp_cycles(input int w, input int h);
    return (h - 2) * (6 + (w - 2) * 4) + border_writes(w, h);
  endfunction

  function automatic int rot_min(input int c);
    int b = c;
    for (int k = 1; k < 8; k++) begin
      int r = ((c >> k) | (c << (8 - k))) & 255;
      if (r < b) b = r;
    end
    return b;
  endfunction

  // Reference: every interior pixel in raster order, then (optionally) all border addresses as zero.
  task automatic build_model(input int w, input int h, input bit m);
    exp_a.delete();
    exp_d.delete();
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        int ctr = int'(img[r * w + c]);
        int code = 0;
        int k = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
              if (int'(img[(r + dr) * w + c + dc]) >= ctr) code = code | (1 << k);
              k++;
            end
          end
        end
        exp_a.push_back(r * w + c);
        exp_d.push_back(m ? rot_min(code) : code);
      end
    end
`ifdef LBP_BORDER_WRITE_EN
    for (int a = 0; a < w * h; a++) begin
      if (a / w == 0 || a / w == h - 1 || a % w == 0 || a % w == w - 1) begin
        exp_a.push_back(a);
        exp_d.push_back(0);
      end
    end
`endif
  endtask

  function automatic int count_diffs();
    int n = (got_a.size() > exp_a.size()) ? got_a.size() - exp_a.size() : exp_a.size() - got_a.size();
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) n++;
    return n;
  endfunction

  task automatic fill_random(input int s, input int maxv);
    for (int i = 0; i < w_of(s) * h_of(s); i++) img[i] = 8'($urandom_range(0, maxv));
  endtask

  // Drive one full run on DUT s; returns cycle count, finish gap, stall hold errors, post-finish state.
  task automatic do_run(input int s, input bit m, input bit stall, output int cnt, output bit to,
                        output int gap, output int stall_err, output bit post_ok);
    int limit = exp_cycles(w_of(s), h_of(s)) + 200;
    int held;
    int n;
    bit stalled = 1'b0;
    stall_err = 0;
    gap = -1;
    ready[s] = 1'b0;
    rst_n[s] = 1'b0;
    @(negedge clk);
    sel = s;
    got_a.delete();
    got_d.delete();
    @(negedge clk);
    rst_n[s] = 1'b1;
    mode[s]  = m;
    @(negedge clk);
    ready[s] = 1'b1;
    @(posedge clk);
    cnt = 0;
    to  = 1'b1;
    while (cnt < limit) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      #1;
      if (fin[s] === 1'b1) begin
        to  = 1'b0;
        gap = cyc - last_wr_cyc;
        break;
      end
      if (stall && !stalled && got_a.size() == 1) begin
        stalled  = 1'b1;
        ready[s] = 1'b0;
        #1;
        held = int'(gaddr[s]);
        for (int i = 0; i < 10; i++) begin
          if (req[s] !== 1'b0 || int'(gaddr[s]) != held) stall_err++;
          @(negedge clk);
          #1;
        end
        ready[s] = 1'b1;
      end
    end
    n = got_a.size();
    repeat (5) @(negedge clk);
    #1;
    post_ok = (got_a.size() == n) && (fin[s] === 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    for (int s = 0; s < NDUT; s++) begin
      total++;
      if (req[s] !== 1'b0 || gaddr[s] !== 32'd0 || vld[s] !== 1'b0 || waddr[s] !== 32'd0 ||
          wdata[s] !== 32'd0 || fin[s] !== 1'b0) begin
        bad++;
        $display("FAIL reset_values dut%0d: req=%b addr=%0h vld=%b waddr=%0h wdata=%0h fin=%b, required all 0",
                 s, req[s], gaddr[s], vld[s], waddr[s], wdata[s], fin[s]);
      end
    end
  endtask

  task automatic test_spec_vector(input bit m, input int want);
    int cnt, gap, se;
    bit to, pok;
    int pix[9] = '{60, 40, 50, 10, 50, 70, 50, 20, 90};
    for (int i = 0; i < 9; i++) img[i] = 8'(pix[i]);
    do_run(0, m, 1'b0, cnt, to, gap, se, pok);
    build_model(3, 3, m);
    total++;
    if (to) begin bad++; $display("FAIL vec3x3_timeout mode=%0d: finish never rose", m); end
    total++;
    if (got_a.size() < 1 || got_a[0] != 4 || got_d[0] != want) begin
      bad++;
      $display("FAIL vec3x3_first mode=%0d: writes=%0d addr=%0d data=%0h, required addr=4 data=%0h",
               m, got_a.size(), (got_a.size() > 0) ? got_a[0] : -1, (got_d.size() > 0) ? got_d[0] : -1, want);
    end
    total++;
    if (count_diffs() != 0) begin
      bad++;
      $display("FAIL vec3x3_stream mode=%0d: writes=%0d diffs=%0d, required writes=%0d diffs=0",
               m, got_a.size(), count_diffs(), exp_a.size());
    end
    total++;
    if (gap != 1) begin bad++; $display("FAIL vec3x3_finish_gap mode=%0d: got %0d, required 1", m, gap); end
    total++;
    if (!pok) begin bad++; $display("FAIL vec3x3_after_finish mode=%0d: extra writes or finish dropped", m); end
  endtask

  task automatic test_random_images();
    int cnt, gap, se;
    bit to, pok, m;
    for (int it = 0; it < 6; it++) begin
      int s = (it % 2 == 0) ? 1 : 2;
      m = 1'($urandom_range(0, 1));
      fill_random(s, (it < 3) ? 255 : 3);
      do_run(s, m, 1'b0, cnt, to, gap, se, pok);
      build_model(w_of(s), h_of(s), m);
      total++;
      if (to || count_diffs() != 0) begin
        bad++;
        $display("FAIL random_stream it=%0d dut%0d mode=%0d: timeout=%0d writes=%0d diffs=%0d, required writes=%0d diffs=0",
                 it, s, m, to, got_a.size(), count_diffs(), exp_a.size());
      end
      total++;
      if (cnt < exp_cycles(w_of(s), h_of(s)) - 2 || cnt > exp_cycles(w_of(s), h_of(s)) + 2) begin
        bad++;
        $display("FAIL random_cycles it=%0d: got %0d, required %0d+-2", it, cnt, exp_cycles(w_of(s), h_of(s)));
      end
      total++;
      if (gap != 1 || !pok) begin
        bad++;
        $display("FAIL random_finish it=%0d: gap=%0d post_ok=%0d, required gap=1 post_ok=1", it, gap, pok);
      end
    end
  endtask

  task automatic test_stall();
    int cnt, gap, se;
    bit to, pok;
    fill_random(1, 255);
    do_run(1, 1'b0, 1'b1, cnt, to, gap, se, pok);
    build_model(5, 4, 1'b0);
    total++;
    if (se != 0) begin bad++; $display("FAIL stall_hold: %0d cycles with req or addr moving, required 0", se); end
    total++;
    if (to || count_diffs() != 0) begin
      bad++;
      $display("FAIL stall_stream: timeout=%0d writes=%0d diffs=%0d, required writes=%0d diffs=0",
               to, got_a.size(), count_diffs(), exp_a.size());
    end
  endtask

  task automatic test_reset_midrun();
    int cnt, gap, se;
    bit to, pok;
    fill_random(1, 255);
    ready[1] = 1'b0;
    rst_n[1] = 1'b0;
    @(negedge clk);
    sel = 1;
    rst_n[1] = 1'b1;
    mode[1]  = 1'b1;
    @(negedge clk);
    ready[1] = 1'b1;
    repeat (23) @(negedge clk);
    #2;
    rst_n[1] = 1'b0;
    #1;
    total++;
    if (req[1] !== 1'b0 || gaddr[1] !== 32'd0 || vld[1] !== 1'b0 || waddr[1] !== 32'd0 ||
        wdata[1] !== 32'd0 || fin[1] !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: req=%b addr=%0h vld=%b waddr=%0h wdata=%0h fin=%b, required all 0",
               req[1], gaddr[1], vld[1], waddr[1], wdata[1], fin[1]);
    end
    do_run(1, 1'b1, 1'b0, cnt, to, gap, se, pok);
    build_model(5, 4, 1'b1);
    total++;
    if (to || count_diffs() != 0) begin
      bad++;
      $display("FAIL midrun_rerun: timeout=%0d writes=%0d diffs=%0d, required writes=%0d diffs=0",
               to, got_a.size(), count_diffs(), exp_a.size());
    end
  endtask

  task automatic test_big_flat();
    int cnt, gap, se, low;
    bit to, pok;
    for (int i = 0; i < 16384; i++) img[i] = 8'h33;
    do_run(3, 1'($urandom_range(0, 1)), 1'b0, cnt, to, gap, se, pok);
    build_model(128, 128, 1'b0);
    total++;
    if (got_a.size() != 15876 + border_writes(128, 128)) begin
      bad++;
      $display("FAIL big_write_count: got %0d, required %0d", got_a.size(), 15876 + border_writes(128, 128));
    end
    total++;
    if (count_diffs() != 0) begin
      bad++;
      $display("FAIL big_stream: diffs=%0d, required 0", count_diffs());
    end
    low = 0;
    for (int i = 0; i < got_a.size(); i++) if (got_a[i] < 128 && got_d[i] != 0) low++;
    total++;
    if (low != 0) begin bad++; $display("FAIL big_top_row: %0d coded writes to addr<128, required 0", low); end
    total++;
    if (to || cnt < exp_cycles(128, 128) - 2 || cnt > exp_cycles(128, 128) + 2) begin
      bad++;
      $display("FAIL big_cycles: timeout=%0d got %0d, required %0d+-2", to, cnt, exp_cycles(128, 128));
    end
  endtask

  initial begin
    for (int s = 0; s < NDUT; s++) begin
      rst_n[s] = 1'b0;
      mode[s]  = 1'b0;
      ready[s] = 1'b0;
    end
    for (int i = 0; i < 16384; i++) img[i] = 8'h00;
    test_reset();
    test_spec_vector(1'b0, 8'hB5);
    test_spec_vector(1'b1, 8'h5B);
    test_random_images();
    test_stall();
    test_reset_midrun();
    test_big_flat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lbp_engine_param.md
Name: lbp_engine_param

Overview:
- Parametrised successor to the fixed 128x128 LBP block.
- Streams a grayscale image of IMG_W x IMG_H pixels from the gray memory over the existing gray_req/gray_addr/gray_data handshake.
- Computes a 3x3 local binary pattern per interior pixel: standard or rotation-invariant, selected per run.
- Writes results to the LBP memory via lbp_addr/lbp_valid/lbp_data, then raises finish.

Parameters:
IMG_W, 128, image width in pixels (>=3)
IMG_H, 128, image height in pixels (>=3)
ADDR_W, 14, address width; 2^ADDR_W >= IMG_W*IMG_H required
DATA_W, 8, gray sample width; LBP code is always 8 bits

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
gray_ready  input  1  source memory ready; fetches advance only while 1
lbp_mode  input  1  0 = standard LBP, 1 = rotation-invariant LBP; sampled when leaving IDLE
gray_req  output  1  read request, 1 in every fetch cycle where gray_ready=1
gray_addr  output  ADDR_W  read address = row*IMG_W + col
gray_data  input  DATA_W  read data, valid in the same cycle as gray_req, captured at the next rising clk
lbp_addr  output  ADDR_W  write address of the current result
lbp_valid  output  1  one-cycle write strobe; memory samples on falling edge
lbp_data  output  8  LBP code
finish  output  1  1 once all results are written; held until reset

Behaviour:
- Reset values: gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0, FSM=IDLE, row=1, col=1.
- Window: 3x3 registers g0..g8, row-major. g0 is top-left, g4 is the centre, g8 is bottom-right.
- Bit k of the code is set when neighbour n_k >= g4 (unsigned). Neighbour order k=0..7 is g0,g1,g2,g3,g5,g6,g7,g8.
- Rotation-invariant code: minimum over all 8 circular right-rotations of the standard code.
- Addresses come from row/col counters plus incrementers; no multiplier.
- FSM states:
  - IDLE -> LOAD when gray_ready=1; latch lbp_mode.
  - LOAD: 6 reads, columns col-1 then col, rows row-1, row, row+1 in that order -> FETCH.
  - FETCH: 3 reads of column col+1, rows row-1..row+1 -> EMIT.
  - EMIT: lbp_valid=1 for one cycle with lbp_addr=row*IMG_W+col; shift window left.
    - col < IMG_W-2: col++, -> FETCH.
    - Else if row < IMG_H-2: row++, col=1, -> LOAD.
    - Else -> DONE.
  - DONE: finish=1, gray_req=0, no further writes; remain until reset.
- Timing: 4 cycles per result plus 6 per row start. Default image: 126*(6+126*4) = 64260 active cycles; 15876 writes.
- gray_ready=0 during LOAD/FETCH: gray_req=0, the read counter holds, window unchanged; resume at the same address. EMIT and DONE ignore gray_ready.
- Border pixels (row or col of 0 or max) are never written in the base build.
- reset=0 mid-run: immediate return to reset values; any partial window is discarded. A new run starts on the next gray_ready=1.
- lbp_mode changes after leaving IDLE have no effect until the next run.

Optional Feature:
- Macro: LBP_BORDER_WRITE_EN.
- Defined: a BORDER state follows the last EMIT. It writes lbp_data=0 to every border address, one per cycle, in ascending address order, with no gray reads. Then -> DONE. Total writes = IMG_W*IMG_H.
- Undefined: BORDER state absent; border memory untouched.

Test Plan:
- IMG_W=IMG_H=3, lbp_mode=0, rows 60 40 50 / 10 50 70 / 50 20 90 -> single write addr 4, lbp_data=0xB5; finish rises 1 cycle later.
- Same image, lbp_mode=1 -> addr 4, lbp_data=0x5B.
- Default 128x128, flat image of value 0x33 -> 15876 writes, all data 0xFF; addresses 0..127 untouched; finish after 64260+-2 cycles from gray_ready.
- IMG_W=5, IMG_H=4, gray_ready low for 10 cycles mid-FETCH -> gray_req=0 and gray_addr frozen during the stall; written codes identical to the unstalled run.
- reset pulsed low mid-run, then rerun -> outputs 0 immediately; rerun results and write count match a clean run.
- LBP_BORDER_WRITE_EN defined, 4x4 image -> 16 writes, the 12 border addresses get 0, last write at addr 15, then finish.
